// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// Stage 1 registers the operation; stage 2 computes and registers the result and flags.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_NOR = 4'd6;
    localparam logic [3:0] OP_SLL = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
    localparam logic [3:0] OP_SRA = 4'd9;
    localparam logic [3:0] OP_RL  = 4'd10;
    localparam logic [3:0] OP_RR  = 4'd11;
    localparam logic [3:0] OP_EQ  = 4'd12;

    logic             s1_valid_reg;
    logic [3:0]       s1_ctrl_reg;
    logic [WIDTH-1:0] s1_x_reg;
    logic [WIDTH-1:0] s1_y_reg;

    logic             s2_valid_reg;
    logic [WIDTH-1:0] out_reg;
    logic             carry_reg;
    logic             zero_reg;
    logic             err_reg;

    logic s2_adv;
    logic s1_adv;
    logic in_fire;

    assign s2_adv   = !s2_valid_reg || out_ready;
    assign s1_adv   = s1_valid_reg && s2_adv;
    assign in_ready = !s1_valid_reg || s1_adv;
    assign in_fire  = in_valid && in_ready;

    // Left shifts and rotates reuse the right-direction barrel by bit-reversing
    // the operand on the way in and the result on the way out.
    logic             sh_left;
    logic             sh_rot;
    logic             sh_fill;
    logic [WIDTH-1:0] x_rev;
    logic [WIDTH-1:0] sh_src;
    logic [WIDTH-1:0] sh_out;
    logic [WIDTH-1:0] sh_rev;
    logic [WIDTH-1:0] sh_result;

    assign sh_left = (s1_ctrl_reg == OP_SLL) || (s1_ctrl_reg == OP_RL);
    assign sh_rot  = (s1_ctrl_reg == OP_RL)  || (s1_ctrl_reg == OP_RR);
    assign sh_fill = (s1_ctrl_reg == OP_SRA) && s1_x_reg[WIDTH-1];

    genvar gi;
    genvar bi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign x_rev[gi]  = s1_x_reg[WIDTH-1-gi];
            assign sh_rev[gi] = sh_out[WIDTH-1-gi];
        end

        // Stage gi moves data right by 2**gi when amount bit gi is set; bits
        // falling off the bottom either wrap (rotate) or take the fill value.
        for (gi = 0; gi < SHW; gi++) begin : g_sh
            logic [WIDTH-1:0] d_in;
            logic [WIDTH-1:0] d_out;
            if (gi == 0) begin : g_first
                assign d_in = sh_src;
            end else begin : g_chain
                assign d_in = g_sh[gi-1].d_out;
            end
            for (bi = 0; bi < WIDTH; bi++) begin : g_bit
                if (bi + (1 << gi) < WIDTH) begin : g_inside
                    assign d_out[bi] = s1_y_reg[gi] ? d_in[bi + (1 << gi)] : d_in[bi];
                end else begin : g_edge
                    assign d_out[bi] = s1_y_reg[gi]
                                     ? (sh_rot ? d_in[bi + (1 << gi) - WIDTH] : sh_fill)
                                     : d_in[bi];
                end
            end
        end
    endgenerate

    assign sh_src    = sh_left ? x_rev : s1_x_reg;
    assign sh_out    = g_sh[SHW-1].d_out;
    assign sh_result = sh_left ? sh_rev : sh_out;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] res_next;
    logic             carry_next;
    logic             zero_next;
    logic             err_next;

    assign sum_ext  = {1'b0, s1_x_reg} + {1'b0, s1_y_reg};
    assign diff_ext = {1'b0, s1_x_reg} - {1'b0, s1_y_reg};

    always_comb begin
        res_next   = '0;
        carry_next = 1'b0;
        err_next   = 1'b0;
        case (s1_ctrl_reg)
            OP_ADD: {carry_next, res_next} = sum_ext;
            OP_SUB: {carry_next, res_next} = diff_ext;
            OP_AND: res_next = s1_x_reg & s1_y_reg;
            OP_OR:  res_next = s1_x_reg | s1_y_reg;
            OP_NOT: res_next = ~s1_x_reg;
            OP_XOR: res_next = s1_x_reg ^ s1_y_reg;
            OP_NOR: res_next = ~(s1_x_reg | s1_y_reg);
            OP_SLL, OP_SRL, OP_SRA, OP_RL, OP_RR: res_next = sh_result;
            OP_EQ:  res_next = {{(WIDTH-1){1'b0}}, (s1_x_reg == s1_y_reg)};
            default: err_next = 1'b1;
        endcase
        zero_next = (res_next == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_ctrl_reg  <= '0;
            s1_x_reg     <= '0;
            s1_y_reg     <= '0;
        end else if (in_fire) begin
            s1_valid_reg <= 1'b1;
            s1_ctrl_reg  <= ctrl;
            s1_x_reg     <= x;
            s1_y_reg     <= y;
        end else if (s1_adv) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // Result and flags change only when a new operation lands in stage 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            out_reg      <= '0;
            carry_reg    <= 1'b0;
            zero_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_reg   <= res_next;
                carry_reg <= carry_next;
                zero_reg  <= zero_next;
                err_reg   <= err_next;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign out       = out_reg;
    assign carry     = carry_reg;
    assign zero      = zero_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: an 8-bit and a 16-bit instance share clock and reset.
module tb_alu_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, carry8, zero8, err8;
    logic [3:0] ctrl8;
    logic [7:0] x8, y8, out8;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, carry16, zero16, err16;
    logic [3:0]  ctrl16;
    logic [15:0] x16, y16, out16;

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .ctrl(ctrl8), .x(x8), .y(y8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out(out8),
        .carry(carry8), .zero(zero8), .err(err8)
    );

    alu_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16), .ctrl(ctrl16), .x(x16), .y(y16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out(out16),
        .carry(carry16), .zero(zero16), .err(err16)
    );

    int checks = 0;
    int failures = 0;

    // Issues one operation into an idle pipe and waits for its result.
    // lat counts edges after the acceptance edge before out_valid is seen.
    task automatic run_op(input bit w16, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, output logic [15:0] r, output logic c,
                          output logic z, output logic e, output int lat);
        bit got;
        got = 1'b0;
        lat = -1;
        r = '0; c = 1'b0; z = 1'b0; e = 1'b0;
        @(negedge clk);
        if (w16) begin
            in_valid16 = 1'b1; ctrl16 = op; x16 = a; y16 = b; out_ready16 = 1'b1;
        end else begin
            in_valid8 = 1'b1; ctrl8 = op; x8 = a[7:0]; y8 = b[7:0]; out_ready8 = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        in_valid16 = 1'b0;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk);
            if (w16 ? out_valid16 : out_valid8) begin
                got = 1'b1;
                lat = n + 1;
                r = w16 ? out16 : {8'h00, out8};
                c = w16 ? carry16 : carry8;
                z = w16 ? zero16 : zero8;
                e = w16 ? err16 : err8;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL timeout op=%0d: out_valid never rose within 8 cycles", op);
        end
    endtask

    task automatic test_reset();
        int stale;
        checks++;
        if (out_valid8 !== 1'b0 || out8 !== 8'h00 || carry8 !== 1'b0 || err8 !== 1'b0 || zero8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_initial: out_valid=%b out=%h carry=%b zero=%b err=%b, required all 0",
                     out_valid8, out8, carry8, zero8, err8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready8 !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready8);
        end
        // Fill the pipe with a stalled output, then reset mid-cycle.
        in_valid8 = 1'b1; ctrl8 = 4'd0; x8 = 8'h01; y8 = 8'h01; out_ready8 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid8 !== 1'b1) begin
            failures++;
            $display("FAIL reset_prefill: out_valid=%b required 1", out_valid8);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid8 !== 1'b0 || out8 !== 8'h00 || carry8 !== 1'b0 || err8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: out_valid=%b out=%h carry=%b err=%b, required all 0",
                     out_valid8, out8, carry8, err8);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid8) stale++;
        end
        checks++;
        if (stale !== 0) begin
            failures++;
            $display("FAIL reset_no_stale: %0d stale results, required 0", stale);
        end
        $display("test_reset done");
    endtask

    task automatic test_carry();
        logic [15:0] r; logic c, z, e; int lat;
        run_op(1'b0, 4'd0, 16'h00F0, 16'h0020, r, c, z, e, lat);
        checks++;
        if (r[7:0] !== 8'h10 || c !== 1'b1 || z !== 1'b0) begin
            failures++;
            $display("FAIL add_carry: out=%h carry=%b zero=%b, required 10 1 0", r[7:0], c, z);
        end
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL latency: %0d edges after acceptance edge, required 2", lat);
        end
        @(negedge clk);
        checks++;
        if (out_valid8 !== 1'b0 || out8 !== 8'h10 || carry8 !== 1'b1) begin
            failures++;
            $display("FAIL drain_hold: out_valid=%b out=%h carry=%b, required 0 10 1",
                     out_valid8, out8, carry8);
        end
        run_op(1'b0, 4'd1, 16'h0005, 16'h0007, r, c, z, e, lat);
        checks++;
        if (r[7:0] !== 8'hFE || c !== 1'b1 || z !== 1'b0) begin
            failures++;
            $display("FAIL sub_borrow: out=%h carry=%b zero=%b, required FE 1 0", r[7:0], c, z);
        end
        run_op(1'b0, 4'd1, 16'h0033, 16'h0033, r, c, z, e, lat);
        checks++;
        if (r[7:0] !== 8'h00 || c !== 1'b0 || z !== 1'b1) begin
            failures++;
            $display("FAIL sub_zero: out=%h carry=%b zero=%b, required 00 0 1", r[7:0], c, z);
        end
        $display("test_carry done");
    endtask

    task automatic test_shift();
        logic [3:0] ops [5] = '{4'd7, 4'd8, 4'd9, 4'd10, 4'd11};
        logic [7:0] exp3 [5] = '{8'hB0, 8'h12, 8'hF2, 8'hB4, 8'hD2};
        logic [15:0] r; logic c, z, e; int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(1'b0, ops[i], 16'h0096, 16'h0003, r, c, z, e, lat);
            checks++;
            if (r[7:0] !== exp3[i] || c !== 1'b0) begin
                failures++;
                $display("FAIL shift_amt3 op=%0d: out=%h carry=%b, required %h 0", ops[i], r[7:0], c, exp3[i]);
            end
            run_op(1'b0, ops[i], 16'h0096, 16'h00F8, r, c, z, e, lat);
            checks++;
            if (r[7:0] !== 8'h96) begin
                failures++;
                $display("FAIL shift_amt0 op=%0d: out=%h, required 96", ops[i], r[7:0]);
            end
        end
        $display("test_shift done");
    endtask

    task automatic test_eq_err();
        logic [15:0] r; logic c, z, e; int lat;
        run_op(1'b0, 4'd12, 16'h005A, 16'h005A, r, c, z, e, lat);
        checks++;
        if (r[7:0] !== 8'h01 || z !== 1'b0) begin
            failures++;
            $display("FAIL eq_true: out=%h zero=%b, required 01 0", r[7:0], z);
        end
        run_op(1'b0, 4'd12, 16'h005A, 16'h005B, r, c, z, e, lat);
        checks++;
        if (r[7:0] !== 8'h00 || z !== 1'b1) begin
            failures++;
            $display("FAIL eq_false: out=%h zero=%b, required 00 1", r[7:0], z);
        end
        run_op(1'b0, 4'hE, 16'h00FF, 16'h00FF, r, c, z, e, lat);
        checks++;
        if (r[7:0] !== 8'h00 || e !== 1'b1 || z !== 1'b1 || c !== 1'b0) begin
            failures++;
            $display("FAIL illegal: out=%h err=%b zero=%b carry=%b, required 00 1 1 0", r[7:0], e, z, c);
        end
        run_op(1'b0, 4'd5, 16'h00F0, 16'h003C, r, c, z, e, lat);
        checks++;
        if (r[7:0] !== 8'hCC || e !== 1'b0) begin
            failures++;
            $display("FAIL after_illegal: out=%h err=%b, required CC 0", r[7:0], e);
        end
        $display("test_eq_err done");
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_out [6] = '{8'h55, 8'h85, 8'hB5, 8'hE5, 8'h15, 8'h45};
        logic       exp_c   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int sent, recv, first_valid, drop_sent, gaps, last_rx;
        logic [7:0] held;
        bit holding, acc, tx;
        sent = 0; recv = 0; first_valid = -1; drop_sent = -1; gaps = 0; last_rx = -1;
        holding = 1'b0; held = '0;
        for (int cyc = 1; cyc <= 30 && recv < 6; cyc++) begin
            @(negedge clk);
            out_ready8 = !(cyc >= 3 && cyc <= 6);
            in_valid8  = (sent < 6);
            ctrl8 = 4'd0;
            x8 = 8'h30 * sent[7:0];
            y8 = 8'h55;
            #1;
            if (out_valid8 && first_valid < 0) first_valid = cyc;
            if (!in_ready8 && drop_sent < 0) drop_sent = sent;
            if (holding && out_valid8) begin
                checks++;
                if (out8 !== held) begin
                    failures++;
                    $display("FAIL hold_stable cyc=%0d: out=%h, required %h", cyc, out8, held);
                end
            end
            holding = out_valid8 && !out_ready8;
            held = out8;
            acc = in_valid8 && in_ready8;
            tx  = out_valid8 && out_ready8;
            if (tx) begin
                checks++;
                if (out8 !== exp_out[recv] || carry8 !== exp_c[recv]) begin
                    failures++;
                    $display("FAIL b2b_result #%0d: out=%h carry=%b, required %h %b",
                             recv, out8, carry8, exp_out[recv], exp_c[recv]);
                end
                if (last_rx >= 0 && cyc != last_rx + 1) gaps++;
                last_rx = cyc;
                recv++;
            end
            if (acc) sent++;
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        checks++;
        if (recv !== 6) begin
            failures++;
            $display("FAIL b2b_count: received %0d, required 6", recv);
        end
        checks++;
        if (drop_sent !== 2) begin
            failures++;
            $display("FAIL b2b_ready_drop: in_ready fell after %0d acceptances, required 2", drop_sent);
        end
        checks++;
        if (first_valid !== 3) begin
            failures++;
            $display("FAIL b2b_first_valid: cycle %0d, required 3", first_valid);
        end
        checks++;
        if (gaps !== 0) begin
            failures++;
            $display("FAIL b2b_throughput: %0d gaps after stall, required 0", gaps);
        end
        $display("test_back_to_back done sent=%0d recv=%0d", sent, recv);
    endtask

    task automatic test_width16();
        logic [15:0] r; logic c, z, e; int lat;
        run_op(1'b1, 4'd9, 16'h8000, 16'h000F, r, c, z, e, lat);
        checks++;
        if (r !== 16'hFFFF) begin
            failures++;
            $display("FAIL w16_sra: out=%h, required FFFF", r);
        end
        run_op(1'b1, 4'd0, 16'hFFFF, 16'h0001, r, c, z, e, lat);
        checks++;
        if (r !== 16'h0000 || c !== 1'b1 || z !== 1'b1) begin
            failures++;
            $display("FAIL w16_add_wrap: out=%h carry=%b zero=%b, required 0000 1 1", r, c, z);
        end
        run_op(1'b1, 4'd10, 16'h1234, 16'h0004, r, c, z, e, lat);
        checks++;
        if (r !== 16'h2341) begin
            failures++;
            $display("FAIL w16_rl: out=%h, required 2341", r);
        end
        $display("test_width16 done");
    endtask

    initial begin
        in_valid8 = 1'b0; out_ready8 = 1'b1; ctrl8 = '0; x8 = '0; y8 = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b1; ctrl16 = '0; x16 = '0; y16 = '0;
        #1;
        test_reset();
        test_carry();
        test_shift();
        test_eq_err();
        test_back_to_back();
        test_width16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
